// File: rtl/ticket_dispense_ctrl.sv
// ticket_dispense_ctrl
//   Sequences one dispense job. It issues the requested tickets one at a time
//   to the ticket mechanism, then releases the change as the fewest coins
//   ($10, $5 and $1 coins, largest first) through the coin hopper.
//
//   Optional feature (macro DISPENSE_TIMEOUT_EN): a request that waits
//   TIMEOUT_CYC cycles without an ack drops, sets the sticky fault flag, and
//   parks the controller in FAULT until reset.
//
// Ports
//   clk        clock; all state changes on its rising edge
//   reset      asynchronous, active-low reset
//   start      one-cycle pulse: accept a job (ignored while busy)
//   tickets    tickets to issue (1..5 accepted), sampled on start
//   change     change owed in dollars (0..127), sampled on start
//   tkt_req    request for one ticket          / tkt_ack   ticket issued
//   coin_req   request for one coin            / coin_ack  coin released
//   coin_sel   coin value while coin_req=1: 2=$10, 1=$5, 0=$1
//   busy       high in every state except IDLE
//   done       one-cycle pulse when a job completes
//   reject     one-cycle pulse when a start in IDLE/FAULT is refused
//   tkt_left   tickets still to issue
//   chg_left   dollars of change still to release
//   fault      sticky handshake-timeout flag (tied 0 without the macro)
//   dbg_state  current FSM state encoding, for debug and checkers
//
// Handshake (both channels): the request is a registered level held high
// until its ack is sampled high on a rising edge. On that edge the request
// drops for exactly one cycle and the matching counter is updated; it
// re-asserts the following cycle if items remain. An ack seen while its own
// request is low is ignored.
module ticket_dispense_ctrl #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] tickets,
  input  logic [6:0] change,
  output logic       tkt_req,
  input  logic       tkt_ack,
  output logic       coin_req,
  output logic [1:0] coin_sel,
  input  logic       coin_ack,
  output logic       busy,
  output logic       done,
  output logic       reject,
  output logic [2:0] tkt_left,
  output logic [6:0] chg_left,
  output logic       fault,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_TICKET = 3'd1,
    S_CHANGE = 3'd2,
    S_DONE   = 3'd3
`ifdef DISPENSE_TIMEOUT_EN
    , S_FAULT = 3'd4
`endif
  } state_t;

  state_t     state, state_nxt;
  logic       tkt_req_nxt, coin_req_nxt, reject_nxt;
  logic [1:0] coin_sel_nxt;
  logic [2:0] tkt_left_nxt;
  logic [6:0] chg_left_nxt;
  logic [6:0] coin_amt;

  // Largest coin that still fits in the remaining change.
  function automatic logic [1:0] greedy_sel(input logic [6:0] amt);
    if (amt >= 7'd10)     return 2'd2;
    else if (amt >= 7'd5) return 2'd1;
    else                  return 2'd0;
  endfunction

  function automatic logic [6:0] sel_value(input logic [1:0] sel);
    case (sel)
      2'd2:    return 7'd10;
      2'd1:    return 7'd5;
      default: return 7'd1;
    endcase
  endfunction

`ifdef DISPENSE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
  logic             fault_q, fault_nxt;
  logic             req_waiting, req_accepted;
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      tkt_req  <= 1'b0;
      coin_req <= 1'b0;
      coin_sel <= 2'd0;
      reject   <= 1'b0;
      tkt_left <= 3'd0;
      chg_left <= 7'd0;
`ifdef DISPENSE_TIMEOUT_EN
      tmo_cnt  <= '0;
      fault_q  <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      tkt_req  <= tkt_req_nxt;
      coin_req <= coin_req_nxt;
      coin_sel <= coin_sel_nxt;
      reject   <= reject_nxt;
      tkt_left <= tkt_left_nxt;
      chg_left <= chg_left_nxt;
`ifdef DISPENSE_TIMEOUT_EN
      tmo_cnt  <= tmo_nxt;
      fault_q  <= fault_nxt;
`endif
    end
  end

  // Next-state and next-register logic.
  always_comb begin
    state_nxt    = state;
    tkt_req_nxt  = tkt_req;
    coin_req_nxt = coin_req;
    coin_sel_nxt = coin_sel;
    reject_nxt   = 1'b0;
    tkt_left_nxt = tkt_left;
    chg_left_nxt = chg_left;
    coin_amt     = sel_value(coin_sel);
`ifdef DISPENSE_TIMEOUT_EN
    tmo_nxt      = tmo_cnt;
    fault_nxt    = fault_q;
    req_waiting  = (tkt_req && !tkt_ack) || (coin_req && !coin_ack);
    req_accepted = (tkt_req && tkt_ack) || (coin_req && coin_ack);
`endif

    case (state)
      S_IDLE: begin
        if (start) begin
          if (tickets != 3'd0 && tickets <= 3'd5) begin
            tkt_left_nxt = tickets;
            chg_left_nxt = change;
            tkt_req_nxt  = 1'b1;
            state_nxt    = S_TICKET;
          end else begin
            reject_nxt = 1'b1;
          end
        end
      end

      S_TICKET: begin
        if (tkt_req && tkt_ack) begin
          tkt_req_nxt = 1'b0;
          if (tkt_left != 3'd0) tkt_left_nxt = tkt_left - 3'd1;
          // The drop cycle doubles as the first cycle of the next state, so
          // the two request lines can never overlap.
          if (tkt_left == 3'd1)
            state_nxt = (chg_left != 7'd0) ? S_CHANGE : S_DONE;
        end else if (!tkt_req) begin
          tkt_req_nxt = 1'b1;
        end
      end

      S_CHANGE: begin
        if (coin_req && coin_ack) begin
          coin_req_nxt = 1'b0;
          coin_sel_nxt = 2'd0;
          if (chg_left >= coin_amt) chg_left_nxt = chg_left - coin_amt;
          if (chg_left == coin_amt) state_nxt = S_DONE;
        end else if (!coin_req) begin
          // Coin value is chosen once at request rise and held until the ack.
          coin_req_nxt = 1'b1;
          coin_sel_nxt = greedy_sel(chg_left);
        end
      end

      S_DONE: state_nxt = S_IDLE;

`ifdef DISPENSE_TIMEOUT_EN
      S_FAULT: begin
        if (start) reject_nxt = 1'b1;
      end
`endif

      default: state_nxt = S_IDLE;
    endcase

`ifdef DISPENSE_TIMEOUT_EN
    if (req_accepted) begin
      tmo_nxt = '0;
    end else if (req_waiting) begin
      tmo_nxt = tmo_cnt + 1'b1;
      if (tmo_cnt == TMO_LAST) begin
        state_nxt    = S_FAULT;
        tkt_req_nxt  = 1'b0;
        coin_req_nxt = 1'b0;
        coin_sel_nxt = 2'd0;
        fault_nxt    = 1'b1;
      end
    end
`endif
  end

  // State-decoded outputs.
  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    dbg_state = state;
  end

endmodule

// File: tb/tb_ticket_dispense_ctrl.sv
module tb_ticket_dispense_ctrl;

  localparam int TIMEOUT_CYC = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] tickets;
  logic [6:0] change;
  logic       tkt_req, tkt_ack;
  logic       coin_req, coin_ack;
  logic [1:0] coin_sel;
  logic       busy, done, reject, fault;
  logic [2:0] tkt_left;
  logic [6:0] chg_left;
  logic [2:0] dbg_state;

  int compared   = 0;
  int mismatched = 0;

  // Scoreboard: coin_sel codes the hopper is still owed, in order.
  logic [1:0] exp_q[$];

  // Clock / reset.
  always #5 clk = ~clk;

  ticket_dispense_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .reset(reset), .start(start), .tickets(tickets), .change(change),
    .tkt_req(tkt_req), .tkt_ack(tkt_ack), .coin_req(coin_req), .coin_sel(coin_sel),
    .coin_ack(coin_ack), .busy(busy), .done(done), .reject(reject),
    .tkt_left(tkt_left), .chg_left(chg_left), .fault(fault), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Fewest coins for an amount: as many $10 as fit, then $5, then $1.
  task automatic greedy_fill(input int amount);
    int rem;
    rem = amount;
    exp_q.delete();
    while (rem >= 10) begin exp_q.push_back(2'd2); rem -= 10; end
    while (rem >= 5)  begin exp_q.push_back(2'd1); rem -= 5;  end
    while (rem > 0)   begin exp_q.push_back(2'd0); rem -= 1;  end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tkt_req"},  32'(tkt_req),  0);
    check({tag, "_coin_req"}, 32'(coin_req), 0);
    check({tag, "_coin_sel"}, 32'(coin_sel), 0);
    check({tag, "_busy"},     32'(busy),     0);
    check({tag, "_done"},     32'(done),     0);
    check({tag, "_reject"},   32'(reject),   0);
    check({tag, "_fault"},    32'(fault),    0);
    check({tag, "_tkt_left"}, 32'(tkt_left), 0);
    check({tag, "_chg_left"}, 32'(chg_left), 0);
  endtask

  // Driver + model for one full job. The model tracks the items remaining
  // and whether the previous edge completed a handshake (the gap cycle);
  // from those alone it predicts every output each cycle.
  task automatic run_job(input int t, input int c, input bit noise);
    int  exp_tkt, exp_chg, wait_cnt;
    bit  gap, hs_t, hs_c, e_treq, e_creq, e_done, done_seen;
    logic [1:0] v;
    greedy_fill(c);
    exp_tkt = t; exp_chg = c; gap = 1'b0; wait_cnt = -1; done_seen = 1'b0;
    @(negedge clk);
    start = 1'b1; tickets = 3'(t); change = 7'(c); tkt_ack = 1'b0; coin_ack = 1'b0;
    @(negedge clk);
    start = 1'b0; tickets = 3'($urandom); change = 7'($urandom);
    for (int cyc = 0; cyc < 600; cyc++) begin
      e_treq = !gap && exp_tkt > 0;
      e_creq = !gap && exp_tkt == 0 && exp_chg > 0;
      e_done = gap && exp_tkt == 0 && exp_chg == 0;
      check("tkt_req",  32'(tkt_req),  32'(e_treq));
      check("coin_req", 32'(coin_req), 32'(e_creq));
      check("done",     32'(done),     32'(e_done));
      check("busy",     32'(busy),     1);
      check("reject",   32'(reject),   0);
      check("fault",    32'(fault),    0);
      check("tkt_left", 32'(tkt_left), exp_tkt);
      check("chg_left", 32'(chg_left), exp_chg);
      if (coin_req && exp_q.size() > 0) check("coin_sel", 32'(coin_sel), 32'(exp_q[0]));
      if (e_done) begin done_seen = 1'b1; break; end
      hs_t = 1'b0; hs_c = 1'b0;
      if (e_treq || e_creq) begin
        if (wait_cnt < 0) wait_cnt = $urandom_range(0, 4);
        if (wait_cnt == 0) begin
          hs_t = e_treq; hs_c = e_creq; wait_cnt = -1;
        end else begin
          wait_cnt--;
        end
      end
      // Acks on a channel whose request is low are noise and must be ignored.
      tkt_ack  = e_treq ? hs_t : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
      coin_ack = e_creq ? hs_c : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
      start    = noise && ($urandom_range(0, 5) == 0);
      tickets  = 3'($urandom_range(1, 5));
      change   = 7'($urandom);
      gap = hs_t || hs_c;
      if (hs_t) exp_tkt--;
      if (hs_c) begin
        v = exp_q.pop_front();
        exp_chg -= (v == 2'd2) ? 10 : (v == 2'd1) ? 5 : 1;
      end
      @(negedge clk);
    end
    check("job_completed", 32'(done_seen), 1);
    start = 1'b0; tkt_ack = 1'b0; coin_ack = 1'b0;
    @(negedge clk);
    check("post_job_busy", 32'(busy), 0);
    check("post_job_done", 32'(done), 0);
  endtask

  task automatic reject_case(input int t);
    @(negedge clk);
    start = 1'b1; tickets = 3'(t); change = 7'($urandom);
    @(negedge clk);
    start = 1'b0;
    check("reject_pulse",   32'(reject),   1);
    check("reject_busy",    32'(busy),     0);
    check("reject_tkt_req", 32'(tkt_req),  0);
    check("reject_load",    32'(tkt_left), 0);
    @(negedge clk);
    check("reject_one_cycle", 32'(reject), 0);
    check("reject_idle_busy", 32'(busy),   0);
  endtask

  initial begin
    int  req_cycles;
    bit  reached;
    reset = 1'b0; start = 1'b0; tickets = 3'd0; change = 7'd0;
    tkt_ack = 1'b0; coin_ack = 1'b0;
    #1;
    check_idle_outputs("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check_idle_outputs("after_release");

    // Directed: 3 tickets, $17 change -> coins 10,5,1,1.
    run_job(3, 17, 1'b0);
    // Invalid ticket counts are refused.
    reject_case(0);
    reject_case(6);
    reject_case(7);
    // No change owed: done right after the last ticket, never a coin request.
    run_job(2, 0, 1'b1);
    // Boundaries.
    run_job(1, 0, 1'b0);
    run_job(5, 127, 1'b1);
    run_job(1, 1, 1'b1);

    // Randomized jobs with noise acks and ignored starts.
    for (int n = 0; n < 10; n++)
      run_job($urandom_range(1, 5), $urandom_range(0, 127), 1'b1);

    // Reset mid-change with $7 still owed.
    @(negedge clk);
    start = 1'b1; tickets = 3'd1; change = 7'd7;
    @(negedge clk);
    start = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (coin_req) begin reached = 1'b1; break; end
      tkt_ack = tkt_req;
      @(negedge clk);
    end
    tkt_ack = 1'b0;
    check("mid_reached_change", 32'(reached), 1);
    check("mid_chg_left", 32'(chg_left), 7);
    check("mid_coin_sel", 32'(coin_sel), 1);
    #2 reset = 1'b0;
    #1 check_idle_outputs("async_reset");
    @(negedge clk);
    check("reset_no_done", 32'(done), 0);
    reset = 1'b1;
    run_job(2, 13, 1'b1);

`ifdef DISPENSE_TIMEOUT_EN
    // Ticket ack never arrives: request times out into FAULT.
    @(negedge clk);
    start = 1'b1; tickets = 3'd2; change = 7'd0;
    @(negedge clk);
    start = 1'b0;
    req_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      if (!tkt_req) break;
      req_cycles++;
      @(negedge clk);
    end
    check("timeout_req_cycles", req_cycles, TIMEOUT_CYC);
    check("timeout_fault",   32'(fault),   1);
    check("timeout_tkt_req", 32'(tkt_req), 0);
    check("timeout_busy",    32'(busy),    1);
    start = 1'b1; tickets = 3'd1;
    @(negedge clk);
    start = 1'b0;
    check("fault_reject", 32'(reject), 1);
    check("fault_sticky", 32'(fault),  1);
    reset = 1'b0;
    #1 check("fault_cleared", 32'(fault), 0);
    @(negedge clk);
    reset = 1'b1;
    run_job(1, 6, 1'b0);
`else
    req_cycles = 0;
    check("no_timeout_fault", 32'(fault + 1'b0) + 32'(req_cycles), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
